// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-domain sequencer: state encoding,
// timer width, default hold times and the state-to-output decode.
package pwr_seq_pkg;

  localparam int PWR_TMR_W = 16;

  localparam int DEF_ISO_SETUP_CYC  = 2;
  localparam int DEF_SAVE_CYC       = 1;
  localparam int DEF_RESTORE_CYC    = 1;
  localparam int DEF_CLK_SETTLE_CYC = 2;
  localparam int DEF_PSW_TIMEOUT    = 255;

  typedef enum logic [3:0] {
    ON      = 4'd0,
    ISO     = 4'd1,
    SAVE    = 4'd2,
    CLK_OFF = 4'd3,
    PSW_OFF = 4'd4,
    OFF     = 4'd5,
    PSW_ON  = 4'd6,
    RESTORE = 4'd7,
    CLK_ON  = 4'd8
  } pwr_state_e;

  typedef struct packed {
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic clk_en;
    logic psw_en;
    logic domain_off;
    logic busy;
  } pwr_out_t;

  // Moore decode. Isolation is asserted in every state except ON, so the
  // switch can never be open while the domain outputs are unclamped.
  function automatic pwr_out_t state_outputs(input pwr_state_e st);
    pwr_out_t o;
    o             = '0;
    o.iso_en      = (st != ON);
    o.ret_save    = (st == SAVE);
    o.ret_restore = (st == RESTORE);
    o.clk_en      = (st == ON) || (st == ISO) || (st == SAVE) || (st == CLK_ON);
    o.psw_en      = !((st == PSW_OFF) || (st == OFF));
    o.domain_off  = (st == OFF);
    o.busy        = !((st == ON) || (st == OFF));
    return o;
  endfunction

endpackage

// File: rtl/pwr_domain_seq_ctrl.sv
// Power-sequencing controller for one switchable domain: isolate, save, gate
// clock, open switch on the way down; the reverse on the way up.
module pwr_domain_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int ISO_SETUP_CYC  = DEF_ISO_SETUP_CYC,
  parameter int SAVE_CYC       = DEF_SAVE_CYC,
  parameter int RESTORE_CYC    = DEF_RESTORE_CYC,
  parameter int CLK_SETTLE_CYC = DEF_CLK_SETTLE_CYC,
  parameter int PSW_TIMEOUT    = DEF_PSW_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pd_req,
  input  logic       psw_ack,
  input  logic       err_clr,
  output logic       iso_en,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       clk_en,
  output logic       psw_en,
  output logic       domain_off,
  output logic       busy,
  output logic       err_timeout,
  output pwr_state_e dbg_state
);

  localparam logic [PWR_TMR_W-1:0] TMR_ONE = PWR_TMR_W'(1);

  pwr_state_e           state_q, state_d;
  logic [PWR_TMR_W-1:0] tmr_q, tmr_d, tmr_load;
  logic                 err_q, err_d;
  pwr_out_t             outs_q, outs_d;
  logic                 tmr_last;
  logic                 ack_wait;
  logic                 timeout_hit;

  assign tmr_last = (tmr_q <= TMR_ONE);
  assign ack_wait = (state_q == PSW_OFF) || (state_q == PSW_ON);

  // pd_req is only looked at in ON/OFF; transient states always run to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ON:      if (pd_req)   state_d = ISO;
      ISO:     if (tmr_last) state_d = SAVE;
      SAVE:    if (tmr_last) state_d = CLK_OFF;
      CLK_OFF: if (tmr_last) state_d = PSW_OFF;
      PSW_OFF: if (!psw_ack) state_d = OFF;
      OFF:     if (!pd_req)  state_d = PSW_ON;
      PSW_ON:  if (psw_ack)  state_d = RESTORE;
      RESTORE: if (tmr_last) state_d = CLK_ON;
      CLK_ON:  if (tmr_last) state_d = ON;
      default:               state_d = ON;
    endcase
  end

  always_comb begin
    tmr_load = '0;
    case (state_d)
      ISO:             tmr_load = PWR_TMR_W'(ISO_SETUP_CYC);
      SAVE:            tmr_load = PWR_TMR_W'(SAVE_CYC);
      RESTORE:         tmr_load = PWR_TMR_W'(RESTORE_CYC);
      CLK_OFF, CLK_ON: tmr_load = PWR_TMR_W'(CLK_SETTLE_CYC);
      PSW_OFF, PSW_ON: tmr_load = PWR_TMR_W'(PSW_TIMEOUT);
      default:         tmr_load = '0;
    endcase
  end

  // In the ack-wait states the timer is a timeout counter that parks at 0.
  assign timeout_hit = ack_wait && (state_d == state_q) && (tmr_q == TMR_ONE);

  always_comb begin
    if (state_d != state_q) begin
      tmr_d = tmr_load;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TMR_ONE;
    end else begin
      tmr_d = tmr_q;
    end
  end

  always_comb begin
    err_d = err_q;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  assign outs_d = state_outputs(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ON;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      outs_q  <= state_outputs(ON);
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      outs_q  <= outs_d;
    end
  end

  assign iso_en      = outs_q.iso_en;
  assign ret_save    = outs_q.ret_save;
  assign ret_restore = outs_q.ret_restore;
  assign clk_en      = outs_q.clk_en;
  assign psw_en      = outs_q.psw_en;
  assign domain_off  = outs_q.domain_off;
  assign busy        = outs_q.busy;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwr_domain_seq_ctrl.sv
// Bench for pwr_domain_seq_ctrl: a default-parameter instance runs a vector
// table; a second instance with short holds/timeout runs the timed corners.
module tb_pwr_domain_seq_ctrl;
  import pwr_seq_pkg::*;

  // Expected output bits: {iso_en, ret_save, ret_restore, clk_en, psw_en, domain_off, busy, err_timeout}
  localparam logic [7:0] O_ON     = 8'b0001_1000;
  localparam logic [7:0] O_ISO    = 8'b1001_1010;
  localparam logic [7:0] O_SAVE   = 8'b1101_1010;
  localparam logic [7:0] O_CLKOFF = 8'b1000_1010;
  localparam logic [7:0] O_PSWOFF = 8'b1000_0010;
  localparam logic [7:0] O_OFF    = 8'b1000_0100;
  localparam logic [7:0] O_PSWON  = 8'b1000_1010;
  localparam logic [7:0] O_REST   = 8'b1010_1010;
  localparam logic [7:0] O_CLKON  = 8'b1001_1010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: default parameters ----------------
  logic pd_req, psw_ack, err_clr;
  logic iso_en, ret_save, ret_restore, clk_en, psw_en, domain_off, busy, err_timeout;
  pwr_state_e st;

  pwr_domain_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .pd_req(pd_req), .psw_ack(psw_ack), .err_clr(err_clr),
    .iso_en(iso_en), .ret_save(ret_save), .ret_restore(ret_restore), .clk_en(clk_en),
    .psw_en(psw_en), .domain_off(domain_off), .busy(busy), .err_timeout(err_timeout),
    .dbg_state(st)
  );

  // ---------------- DUT B: ISO_SETUP=1, SAVE=3, PSW_TIMEOUT=10 ----------------
  logic pd_req_b, psw_ack_b, err_clr_b;
  logic iso_en_b, ret_save_b, ret_restore_b, clk_en_b, psw_en_b, domain_off_b, busy_b, err_timeout_b;
  pwr_state_e st_b;

  pwr_domain_seq_ctrl #(.ISO_SETUP_CYC(1), .SAVE_CYC(3), .PSW_TIMEOUT(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pd_req(pd_req_b), .psw_ack(psw_ack_b), .err_clr(err_clr_b),
    .iso_en(iso_en_b), .ret_save(ret_save_b), .ret_restore(ret_restore_b), .clk_en(clk_en_b),
    .psw_en(psw_en_b), .domain_off(domain_off_b), .busy(busy_b), .err_timeout(err_timeout_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int inv_viol = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic       pd_req;
    logic       psw_ack;
    logic       err_clr;
    pwr_state_e st;
    logic [7:0] outs;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] obs_a();
    return {st, iso_en, ret_save, ret_restore, clk_en, psw_en, domain_off, busy, err_timeout};
  endfunction

  function automatic logic [11:0] obs_b();
    return {st_b, iso_en_b, ret_save_b, ret_restore_b, clk_en_b, psw_en_b, domain_off_b, busy_b, err_timeout_b};
  endfunction

  task automatic add_vec(input logic p, input logic a, input logic c,
                         input pwr_state_e s, input logic [7:0] o);
    vec_t v;
    v.pd_req = p; v.psw_ack = a; v.err_clr = c; v.st = s; v.outs = o;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_a(input logic p, input logic a, input logic c);
    @(negedge clk);
    pd_req = p; psw_ack = a; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic p, input logic a, input logic c);
    @(negedge clk);
    pd_req_b = p; psw_ack_b = a; err_clr_b = c;
    @(posedge clk);
    #1;
  endtask

  // The domain must never be unclamped while its switch is open.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!psw_en && !iso_en)     inv_viol++;
      if (!psw_en_b && !iso_en_b) inv_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    logic [11:0] got;
    logic [4:0]  save_pat;
    save_pat = 5'b01110;

    rst_n = 1'b0;
    pd_req = 1'b0; psw_ack = 1'b1; err_clr = 1'b0;
    pd_req_b = 1'b0; psw_ack_b = 1'b1; err_clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs_a(), {ON, O_ON});
    check("reset_b", obs_b(), {ON, O_ON});
    @(negedge clk);
    rst_n = 1'b1;

    // Power-down, power-up, then a pd_req glitch mid-sequence.
    add_vec(0, 1, 0, ON,      O_ON);
    add_vec(1, 1, 0, ISO,     O_ISO);
    add_vec(1, 1, 0, ISO,     O_ISO);
    add_vec(1, 1, 0, SAVE,    O_SAVE);
    add_vec(1, 1, 0, CLK_OFF, O_CLKOFF);
    add_vec(1, 1, 0, CLK_OFF, O_CLKOFF);
    add_vec(1, 1, 0, PSW_OFF, O_PSWOFF);
    add_vec(1, 1, 0, PSW_OFF, O_PSWOFF);
    add_vec(1, 1, 0, PSW_OFF, O_PSWOFF);
    add_vec(1, 0, 0, OFF,     O_OFF);
    add_vec(1, 0, 1, OFF,     O_OFF);
    add_vec(0, 0, 0, PSW_ON,  O_PSWON);
    add_vec(0, 0, 0, PSW_ON,  O_PSWON);
    add_vec(0, 0, 0, PSW_ON,  O_PSWON);
    add_vec(0, 1, 0, RESTORE, O_REST);
    add_vec(0, 1, 0, CLK_ON,  O_CLKON);
    add_vec(0, 1, 0, CLK_ON,  O_CLKON);
    add_vec(0, 1, 0, ON,      O_ON);
    add_vec(1, 1, 0, ISO,     O_ISO);
    add_vec(1, 1, 0, ISO,     O_ISO);
    add_vec(1, 1, 0, SAVE,    O_SAVE);
    add_vec(0, 1, 0, CLK_OFF, O_CLKOFF);
    add_vec(0, 1, 0, CLK_OFF, O_CLKOFF);
    add_vec(1, 1, 0, PSW_OFF, O_PSWOFF);
    add_vec(0, 0, 0, OFF,     O_OFF);
    add_vec(0, 0, 0, PSW_ON,  O_PSWON);
    add_vec(0, 1, 0, RESTORE, O_REST);
    add_vec(0, 1, 0, CLK_ON,  O_CLKON);
    add_vec(0, 1, 0, CLK_ON,  O_CLKON);
    add_vec(0, 1, 0, ON,      O_ON);
    add_vec(0, 1, 0, ON,      O_ON);

    foreach (vecs[i]) begin
      @(negedge clk);
      pd_req = vecs[i].pd_req; psw_ack = vecs[i].psw_ack; err_clr = vecs[i].err_clr;
      exp_q.push_back({vecs[i].st, vecs[i].outs});
      @(posedge clk);
      #1;
      got = obs_a();
      check($sformatf("vec%0d", i), got, exp_q.pop_front());
    end

    // DUT B: short iso setup and a 3-cycle save pulse.
    for (int k = 0; k < 5; k++) begin
      cyc_b(1, 1, 0);
      if (k == 0) check("b_iso_rise", iso_en_b, 1);
      check($sformatf("b_save_cyc%0d", k), ret_save_b, save_pat[k]);
    end
    check("b_state_clk_off", st_b, CLK_OFF);
    cyc_b(1, 1, 0);
    cyc_b(1, 1, 0);
    check("b_state_psw_off", st_b, PSW_OFF);

    // Switch never acknowledges the power-down: timeout after 10 cycles.
    repeat (9) cyc_b(1, 1, 0);
    check("b_no_err_before_timeout", err_timeout_b, 0);
    cyc_b(1, 1, 0);
    check("b_err_at_timeout", err_timeout_b, 1);
    check("b_wait_psw_off", st_b, PSW_OFF);
    repeat (3) cyc_b(1, 1, 0);
    check("b_still_psw_off", {st_b, err_timeout_b}, {PSW_OFF, 1'b1});
    cyc_b(1, 0, 0);
    check("b_off_after_ack", {st_b, domain_off_b, err_timeout_b}, {OFF, 1'b1, 1'b1});
    cyc_b(1, 0, 1);
    check("b_err_cleared", err_timeout_b, 0);
    cyc_b(1, 0, 0);
    check("b_err_stays_clear", err_timeout_b, 0);

    // Power-up timeout with err_clr landing in the very cycle the error sets.
    cyc_b(0, 0, 0);
    check("b_state_psw_on", st_b, PSW_ON);
    repeat (9) cyc_b(0, 0, 0);
    check("b_no_err_psw_on", err_timeout_b, 0);
    cyc_b(0, 0, 1);
    check("b_err_set_beats_clr", {st_b, err_timeout_b}, {PSW_ON, 1'b1});
    cyc_b(0, 1, 0);
    check("b_restore", {st_b, ret_restore_b, err_timeout_b}, {RESTORE, 1'b1, 1'b1});
    cyc_b(0, 1, 0);
    cyc_b(0, 1, 0);
    cyc_b(0, 1, 0);
    check("b_back_on", {st_b, iso_en_b, clk_en_b, psw_en_b, err_timeout_b},
          {ON, 1'b0, 1'b1, 1'b1, 1'b1});

    // Async reset mid-sequence on DUT A (in CLK_OFF); DUT B resets with err set.
    cyc_a(1, 1, 0);
    cyc_a(1, 1, 0);
    cyc_a(1, 1, 0);
    cyc_a(1, 1, 0);
    check("a_pre_reset_clk_off", obs_a(), {CLK_OFF, O_CLKOFF});
    #2;
    rst_n = 1'b0;
    #1;
    check("a_async_reset", obs_a(), {ON, O_ON});
    check("b_async_reset", obs_b(), {ON, O_ON});
    @(negedge clk);
    pd_req = 1'b0;
    rst_n  = 1'b1;
    cyc_a(0, 1, 0);
    check("a_on_after_reset", obs_a(), {ON, O_ON});

    check("iso_psw_invariant", inv_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
